// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin frame arbiter feeding a single MAC transmitter
// Latches a winner's payload, pulses the transmitter, then waits for completion or timeout.
module tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  payload,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done_ack,
  output logic                 mac_tx_en,
  output logic [31:0]          mac_data,
  input  logic                 mac_tx_done,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int PW = $clog2(N_REQ);
  localparam int IW = PW + 1;
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, IFG} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   next_ptr;
  logic            found;
  logic [IW-1:0]   idx;
  logic [15:0]     cnt;
  logic            tx_done_q;
  logic            rise;
  logic            tmo;

  // Search starts at rr_ptr and wraps, so the last winner is considered last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'(rr_ptr) + IW'(k);
      if (idx >= IW'(N_REQ)) idx = idx - IW'(N_REQ);
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  assign next_ptr = (winner == PW'(N_REQ - 1)) ? '0 : winner + 1'b1;
  assign rise     = mac_tx_done & ~tx_done_q;
  assign tmo      = (cnt == TO_LAST);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      winner      <= '0;
      cnt         <= '0;
      tx_done_q   <= 1'b0;
      grant       <= '0;
      done_ack    <= '0;
      mac_tx_en   <= 1'b0;
      mac_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      tx_done_q   <= mac_tx_done;
      done_ack    <= '0;
      timeout_err <= 1'b0;
      mac_tx_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            winner    <= pick;
            grant     <= N_REQ'(1) << pick;
            mac_data  <= payload[32*pick +: 32];
            mac_tx_en <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A genuine completion beats a timeout landing on the same cycle.
          if (rise || tmo) begin
            done_ack    <= rise ? (N_REQ'(1) << winner) : '0;
            timeout_err <= ~rise;
            grant       <= '0;
            rr_ptr      <= next_ptr;
            cnt         <= '0;
            state       <= IFG;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        IFG: begin
          if (cnt == IFG_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb/tb_tx_arbiter.sv - scoreboard bench for tx_arbiter
// Stimulus pushes expected starts/completions; a negedge monitor pops and compares.
module tb_tx_arbiter;

  localparam int N   = 4;
  localparam int IFG = 12;
  localparam int TO  = 2048;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [32*N-1:0] payload = '0;
  logic           mac_tx_done = 1'b0;
  logic [N-1:0]   grant;
  logic [N-1:0]   done_ack;
  logic           mac_tx_en;
  logic [31:0]    mac_data;
  logic           busy;
  logic           timeout_err;

  tx_arbiter #(.N_REQ(N), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .payload(payload),
    .grant(grant), .done_ack(done_ack), .mac_tx_en(mac_tx_en),
    .mac_data(mac_data), .mac_tx_done(mac_tx_done), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [N-1:0] g; logic [31:0] d; int c; } st_t;
  typedef struct { logic [N-1:0] a; logic to; int c; } en_t;
  st_t start_q[$];
  en_t end_q[$];

  int checks = 0;
  int failures = 0;
  int rr = 0;
  int cur_w = 0;
  int idle_at = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  function automatic int pick_rr(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic rand_payload();
    for (int k = 0; k < N; k++) payload[32*k +: 32] = $urandom;
  endtask

  // Winner is decided by the current req/payload; start occurs the cycle after the block is idle.
  task automatic expect_start();
    st_t e;
    int  c;
    cur_w = pick_rr(req, rr);
    c     = cyc;
    e.g   = N'(1) << cur_w;
    e.d   = payload[32*cur_w +: 32];
    e.c   = ((idle_at > c) ? idle_at : c) + 1;
    start_q.push_back(e);
  endtask

  task automatic issue(input logic [N-1:0] r);
    req = r;
    rand_payload();
    expect_start();
  endtask

  task automatic wait_start(input int budget, output int s);
    s = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mac_tx_en) begin
        s = cyc;
        break;
      end
    end
    if (s < 0) begin
      checks++;
      failures++;
      $display("FAIL start_wait no mac_tx_en within %0d cycles", budget);
      finish_run();
    end
  endtask

  task automatic complete(input int s, input int d);
    en_t e;
    int  r;
    while (cyc < s + d) @(negedge clk);
    if (mac_tx_done) begin
      mac_tx_done = 1'b0;
      @(negedge clk);
    end
    mac_tx_done = 1'b1;
    r   = cyc;
    e.a = N'(1) << cur_w;
    e.to = 1'b0;
    e.c = r + 1;
    end_q.push_back(e);
    rr      = (cur_w + 1) % N;
    idle_at = r + 1 + IFG;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_done_ack"}, done_ack, 0);
    chk({tag, "_tx_en"}, mac_tx_en, 0);
    chk({tag, "_data"}, mac_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout"}, timeout_err, 0);
  endtask

  // Monitor
  logic        prev_en = 1'b0;
  logic [31:0] held = '0;
  bit          in_ifg = 0;
  int          ifg_cnt = 0;

  always @(negedge clk) begin
    st_t se;
    en_t ee;
    if (!rst_n) begin
      in_ifg  = 0;
      prev_en = 1'b0;
    end else begin
      chk("grant_onehot0", $onehot0(grant), 1);
      if (grant != 0) chk("grant_implies_busy", busy, 1);
      if (mac_tx_en) begin
        chk("tx_en_single_cycle", prev_en, 0);
        if (start_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start actual=grant %0h required=no start", grant);
        end else begin
          se = start_q.pop_front();
          chk("start_grant", grant, se.g);
          chk("start_data", mac_data, se.d);
          chk("start_cycle", cyc, se.c);
          chk("start_busy", busy, 1);
        end
        held = mac_data;
      end else if (grant != 0) begin
        chk("data_stable", mac_data, held);
      end
      if (done_ack != 0 || timeout_err) begin
        if (end_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_end actual=ack %0h to %0b required=none", done_ack, timeout_err);
        end else begin
          ee = end_q.pop_front();
          chk("end_done_ack", done_ack, ee.a);
          chk("end_timeout_err", timeout_err, ee.to);
          chk("end_cycle", cyc, ee.c);
          chk("end_grant_cleared", grant, 0);
        end
        in_ifg  = 1;
        ifg_cnt = 1;
      end else if (in_ifg) begin
        if (busy) ifg_cnt++;
        else begin
          chk("ifg_length", ifg_cnt, IFG);
          in_ifg = 0;
        end
      end
      prev_en = mac_tx_en;
    end
  end

  initial begin
    int s;
    en_t te;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n   = 1'b1;
    idle_at = cyc;
    rr      = 0;

    // Round robin with all four requesting: 0,1,2,3,0
    @(negedge clk);
    issue(4'b1111);
    for (int f = 0; f < 5; f++) begin
      wait_start(100, s);
      complete(s, 5);
      if (f < 4) expect_start();
      else begin
        req = 4'b0100;
        payload[95:64] = 32'hDEADBEEF;
        expect_start();
      end
      @(negedge clk);
      mac_tx_done = 1'b0;
    end

    // Single requester, done 20 cycles after start, done left high
    wait_start(100, s);
    complete(s, 20);

    // Sticky done: next frame must wait for a fresh low->high
    req = 4'b1001;
    rand_payload();
    expect_start();
    wait_start(100, s);
    complete(s, 15);
    issue(4'b0010);
    @(negedge clk);
    mac_tx_done = 1'b0;

    // Timeout on requester 1, then requester 2 is next
    wait_start(100, s);
    te.a = '0;
    te.to = 1'b1;
    te.c = s + TO + 1;
    end_q.push_back(te);
    rr      = (cur_w + 1) % N;
    idle_at = s + TO + 1 + IFG;
    issue(4'b0110);
    wait_start(TO + 200, s);

    // Random frames with mid-frame req drop / payload churn
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 1) == 1) begin
        rand_payload();
        if ($urandom_range(0, 1) == 1) req[cur_w] = 1'b0;
      end
      complete(s, $urandom_range(1, 40));
      if (f == 24) issue(4'b1010);
      else issue(N'($urandom_range(1, (1 << N) - 1)));
      @(negedge clk);
      mac_tx_done = 1'b0;
      wait_start(200, s);
    end

    // Reset in the middle of WAIT_DONE with req=1010
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    start_q.delete();
    end_q.delete();
    mac_tx_done = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("hold_rst");
    rr      = 0;
    idle_at = cyc;
    rst_n   = 1'b1;
    expect_start();
    wait_start(20, s);
    complete(s, 3);
    @(negedge clk);
    mac_tx_done = 1'b0;
    req = '0;
    repeat (IFG + 5) @(negedge clk);
    chk("scoreboard_drained", start_q.size() + end_q.size(), 0);
    finish_run();
  end

endmodule
